alu: RTL and testbench
======================

Name: alu

Overview:
- Signed two's-complement arithmetic/logic unit for the processor core datapath.
- Operand a is the accumulator side; operand b is the bus/register side.
- Registered result c: one result per clock, selected by a 3-bit opcode.
- Used by each core of the multicore processor to execute datapath instructions.

Parameters:
- WIDTH, 12, data width in bits of a, b and c (signed two's complement); legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  signed operand A (accumulator side).
- b  input  WIDTH  signed operand B (bus side).
- selectOp  input  3  operation select (encoding below).
- c  output  WIDTH  signed registered result.

Behaviour:
- Reset: synchronous, active-high. When rst=1 at a rising clk edge, c <= 0. rst has priority over every opcode.
- Latency: one cycle. Inputs sampled at rising edge N appear on c after edge N. No handshake; a new operation is accepted every cycle.
- Opcode encoding (selectOp):
  - 0 IDLE: c holds its previous value.
  - 1 CLR: c <= 0.
  - 2 PASS: c <= b.
  - 3 ADD: c <= a + b.
  - 4 SUB: c <= a - b.
  - 5 MUL: c <= low WIDTH bits of the signed product a*b.
  - 6 INC: c <= a + 1.
  - 7 reserved: treated as IDLE (c holds).
- Width rules:
  - All arithmetic is signed, computed modulo 2^WIDTH; overflow wraps silently, no flags.
  - MUL forms the full 2*WIDTH signed product internally, then truncates to WIDTH bits.
- c is a pure register: no combinational path from inputs to c.
- X or undriven inputs before the first valid op produce no special handling. c is defined only after the first reset.
- Reset asserted mid-sequence clears c on that edge. The op presented on the same edge is discarded.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [2:0] alu_op_t: IDLE=0, CLR=1, PASS=2, ADD=3, SUB=4, MUL=5, INC=6, RSVD=7.
  - Default data WIDTH constant (12).
- Core logic: a combinational next-value case on selectOp, followed by a single always_ff register with synchronous reset.
- No sub-module required. A separate signed multiplier (alu_mul) is optional if the target needs a pipelined or DSP-mapped multiply; latency must remain one cycle.

Test Plan:
- Reset: drive rst=1 for 2 cycles with selectOp=ADD, a=5, b=5 -> c=0. Release rst -> c=10 after the next edge.
- a=10, b=3, step selectOp 0..6 one per cycle, expected c after each edge:
  - IDLE: hold.
  - CLR: 0.
  - PASS: 3.
  - ADD: 13.
  - SUB: 7.
  - MUL: 30.
  - INC: 11.
- a=20, b=-30, same opcode sweep, expected c after each edge:
  - PASS: -30.
  - ADD: -10.
  - SUB: 50.
  - MUL: -600.
  - INC: 21.
- Wrap-around (WIDTH=12):
  - ADD 2047+1 -> -2048.
  - SUB -2048-1 -> 2047.
  - MUL 100*100 -> 1808.
  - INC 2047 -> -2048.
- Hold and reserved: after ADD gives 13, apply selectOp=0 then 7 with changed a=1, b=1 -> c stays 13 both cycles.
- Random: 1000 cycles of random a, b, selectOp with occasional rst. A reference model checks c each cycle against the modulo-2^12 rules above.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the datapath ALU.
// Opcode encoding and default data width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        PASS = 3'd2,
        ADD  = 3'd3,
        SUB  = 3'd4,
        MUL  = 3'd5,
        INC  = 3'd6,
        RSVD = 3'd7
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Signed two's-complement ALU with a registered result.
// One op per clock, one-cycle latency, wrap-around arithmetic.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       selectOp,
    output logic [WIDTH-1:0] c
);

    alu_op_t            op;
    logic [WIDTH-1:0]   c_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    assign op = alu_op_t'(selectOp);

    // Sign-extended operands make the unsigned product equal the signed one
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        c_nxt = c;
        unique case (op)
            IDLE: c_nxt = c;
            CLR:  c_nxt = '0;
            PASS: c_nxt = b;
            ADD:  c_nxt = a + b;
            SUB:  c_nxt = a - b;
            MUL:  c_nxt = prod[WIDTH-1:0];
            INC:  c_nxt = a + WIDTH'(1);
            RSVD: c_nxt = c;
            default: c_nxt = c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
        end else begin
            c <= c_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed vectors with literal
// expectations plus a modulo-2^12 reference model checked every cycle.
module tb_alu;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   selectOp;
    logic [W-1:0] c;

    int passed;
    int total;

    int model_c;
    bit model_valid;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .selectOp (selectOp),
        .c        (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap(input longint v);
        longint r;
        r = v % 4096;
        if (r < 0) r = r + 4096;
        if (r >= 2048) r = r - 4096;
        return int'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, wrapped to 12 bits
    always @(posedge clk) begin
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (rst === 1'b1) begin
            model_c     = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            case (selectOp)
                3'd1: model_c = 0;
                3'd2: model_c = wrap(sb);
                3'd3: model_c = wrap(sa + sb);
                3'd4: model_c = wrap(sa - sb);
                3'd5: model_c = wrap(sa * sb);
                3'd6: model_c = wrap(sa + 1);
                default: model_c = model_c;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model", int'($signed(c)), model_c);
        end
    end

    task automatic step(input logic r, input logic [2:0] op,
                        input int aa, input int bb);
        rst      = r;
        selectOp = op;
        a        = aa[W-1:0];
        b        = bb[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string name, input logic r,
                            input logic [2:0] op, input int aa,
                            input int bb, input int exp);
        step(r, op, aa, bb);
        check(name, int'($signed(c)), exp);
    endtask

    int exp_sw1 [7] = '{10, 0, 3, 13, 7, 30, 11};
    int exp_sw2 [7] = '{11, 0, -30, -10, 50, -600, 21};

    initial begin
        passed      = 0;
        total       = 0;
        model_c     = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        selectOp    = 3'd3;
        a           = 12'd5;
        b           = 12'd5;

        step_chk("reset0", 1'b1, 3'd3, 5, 5, 0);
        step_chk("reset1", 1'b1, 3'd3, 5, 5, 0);
        step_chk("release_add", 1'b0, 3'd3, 5, 5, 10);

        for (int i = 0; i < 7; i++) begin
            step_chk($sformatf("sweep1_op%0d", i), 1'b0, 3'(i), 10, 3,
                     exp_sw1[i]);
        end
        for (int i = 0; i < 7; i++) begin
            step_chk($sformatf("sweep2_op%0d", i), 1'b0, 3'(i), 20, -30,
                     exp_sw2[i]);
        end

        step_chk("wrap_add", 1'b0, 3'd3, 2047, 1, -2048);
        step_chk("wrap_sub", 1'b0, 3'd4, -2048, 1, 2047);
        step_chk("wrap_mul", 1'b0, 3'd5, 100, 100, 1808);
        step_chk("wrap_inc", 1'b0, 3'd6, 2047, 0, -2048);
        step_chk("neg_mul", 1'b0, 3'd5, -2048, -1, -2048);

        step_chk("hold_add", 1'b0, 3'd3, 10, 3, 13);
        step_chk("hold_idle", 1'b0, 3'd0, 1, 1, 13);
        step_chk("hold_rsvd", 1'b0, 3'd7, 1, 1, 13);
        step_chk("mid_reset", 1'b1, 3'd3, 10, 3, 0);

        for (int i = 0; i < 1000; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(4095)) - 2048;
            rb = int'($urandom_range(4095)) - 2048;
            step(($urandom_range(19) == 0), 3'($urandom_range(7)), ra, rb);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
